// File: rtl/sqrt_arb_pkg.sv
// Shared types and width helpers for the square-root arbiter slice.
// The sqrt result width tracks the squareroot unit's out_number width.
package sqrt_arb_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESPOND,
    ARB_GAP
  } arb_state_t;

  function automatic int sqrt_out_w(input int n_bits);
    return n_bits / 2 + 1;
  endfunction

  function automatic int timeout_w(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/sqrt_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Returns both the one-hot grant and its index so the top can remember the winner.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[(int'(ptr) + i) % N_REQ]) begin
        any                              = 1'b1;
        grant_idx                        = PTR_W'((int'(ptr) + i) % N_REQ);
        grant[(int'(ptr) + i) % N_REQ]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one squareroot unit between N_REQ requesters with round-robin grants.
// Holds the operand for the whole op, forces a start-low gap afterwards, and aborts hung ops.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int N_BITS      = 32,
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 256,
  localparam int SQ_W  = sqrt_out_w(N_BITS),
  localparam int PTR_W = $clog2(N_REQ),
  localparam int TO_W  = timeout_w(TIMEOUT_CYC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*N_BITS-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [SQ_W-1:0]         rsp_data,
  output logic                    rsp_err,
  output logic                    sq_start,
  output logic [N_BITS-1:0]       sq_number,
  input  logic [SQ_W-1:0]         sq_result,
  input  logic                    sq_valid,
  output logic                    busy
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  arb_state_t        state, state_next;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  grant_idx_q;
  logic [N_BITS-1:0] number_q;
  logic [SQ_W-1:0]   result_q;
  logic              err_q;
  logic [TO_W-1:0]   to_cnt;

  logic [N_REQ-1:0]  grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              any_req;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ARB_IDLE:    if (any_req) state_next = ARB_ISSUE;
      ARB_ISSUE:   state_next = ARB_WAIT;
      ARB_WAIT:    if (sq_valid || to_cnt == TO_LAST) state_next = ARB_RESPOND;
      ARB_RESPOND: state_next = ARB_GAP;
      ARB_GAP:     state_next = ARB_IDLE;
      default:     state_next = ARB_IDLE;
    endcase
  end

  // A real sq_valid beats the timeout when both land in the same WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      grant_idx_q <= '0;
      number_q    <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      to_cnt      <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (any_req) begin
            number_q    <= req_data[int'(grant_idx)*N_BITS +: N_BITS];
            grant_idx_q <= grant_idx;
          end
        end
        ARB_ISSUE: to_cnt <= '0;
        ARB_WAIT: begin
          if (sq_valid) begin
            result_q <= sq_result;
            err_q    <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ARB_RESPOND: begin
          ptr_q <= (grant_idx_q == PTR_W'(N_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    sq_start  = 1'b0;
    busy      = (state != ARB_IDLE);
    unique case (state)
      ARB_IDLE:    if (!rst) req_ready = grant;
      ARB_ISSUE,
      ARB_WAIT:    sq_start = 1'b1;
      ARB_RESPOND: begin
        rsp_valid = N_REQ'(1) << grant_idx_q;
        rsp_data  = result_q;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

  assign sq_number = number_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a behavioural squareroot unit behind it.
// Expected grants/results are hand-computed integer square roots of the driven operands.
module tb_sqrt_arbiter;

  localparam int N_BITS      = 32;
  localparam int N_REQ       = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int SQ_W        = N_BITS / 2 + 1;
  localparam int LAT         = 5;

  typedef struct {
    logic [N_REQ-1:0] vld;
    logic [SQ_W-1:0]  data;
    logic             err;
    int               cyc;
  } rsp_rec_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*N_BITS-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [SQ_W-1:0]         rsp_data;
  logic                    rsp_err;
  logic                    sq_start;
  logic [N_BITS-1:0]       sq_number;
  logic [SQ_W-1:0]         sq_result;
  logic                    sq_valid;
  logic                    busy;

  int         passes = 0;
  int         checks = 0;
  int         cyc = 0;
  rsp_rec_t   rsp_q[$];
  int         grant_q[$];
  int         rise_q[$];
  logic       prev_start = 1'b0;
  int         low_run = 0;
  int         min_low = 1000;
  logic [N_REQ-1:0] hold_mask;

  always #5 clk = ~clk;

  sqrt_arbiter #(.N_BITS(N_BITS), .N_REQ(N_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .sq_start  (sq_start),
    .sq_number (sq_number),
    .sq_result (sq_result),
    .sq_valid  (sq_valid),
    .busy      (busy)
  );

  // Squareroot stand-in: counts while start is high, flags operands 0/1 regardless of start.
  int   sq_cnt = 0;
  logic sqrt_dead = 1'b0;

  always @(posedge clk) begin
    if (!sq_start) sq_cnt <= 0;
    else           sq_cnt <= sq_cnt + 1;
  end

  function automatic logic [SQ_W-1:0] isqrt(input logic [N_BITS-1:0] n);
    longint r = 0;
    if (n[N_BITS-1]) return '0;
    while ((r + 1) * (r + 1) <= longint'(n)) r++;
    return SQ_W'(r);
  endfunction

  assign sq_result = isqrt(sq_number);
  assign sq_valid  = !sqrt_dead && ((sq_number <= 1) || (sq_start && sq_cnt >= LAT));

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    else passes++;
  endtask

  function automatic int onehotIdx(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One clock: observe at negedge, drop accepted requests just after posedge.
  task automatic tick();
    logic [N_REQ-1:0] acc;
    @(negedge clk);
    cyc++;
    if (req_ready != '0) begin
      checkOutput("ready_onehot", 64'($onehot(req_ready)), 1);
      grant_q.push_back(onehotIdx(req_ready));
    end
    if (rsp_valid != '0) begin
      checkOutput("rsp_onehot", 64'($onehot(rsp_valid)), 1);
      rsp_q.push_back('{rsp_valid, rsp_data, rsp_err, cyc});
    end
    if (sq_start && !prev_start) begin
      if (rise_q.size() > 0 && low_run < min_low) min_low = low_run;
      rise_q.push_back(cyc);
    end
    low_run    = sq_start ? 0 : low_run + 1;
    prev_start = sq_start;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = (req_valid & ~acc) | hold_mask;
  endtask

  task automatic applyStimulus(input int idx, input logic [N_BITS-1:0] data);
    req_data[idx*N_BITS +: N_BITS] = data;
    req_valid[idx] = 1'b1;
  endtask

  task automatic clearLogs();
    rsp_q.delete();
    grant_q.delete();
    rise_q.delete();
    min_low = 1000;
  endtask

  task automatic doReset();
    rst       = 1'b1;
    req_valid = '0;
    hold_mask = '0;
    tick();
    tick();
    rst = 1'b0;
    clearLogs();
  endtask

  task automatic runUntilRsp(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && rsp_q.size() < n; k++) tick();
    checkOutput(tag, 64'(rsp_q.size()), 64'(n));
  endtask

  task automatic runUntilGrants(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && grant_q.size() < n; k++) tick();
    checkOutput(tag, 64'(grant_q.size()), 64'(n));
  endtask

  task automatic checkRsp(input string tag, input int k, input logic [N_REQ-1:0] vld,
                          input int data, input logic err);
    if (rsp_q.size() > k) begin
      checkOutput({tag, "_vld"}, 64'(rsp_q[k].vld), 64'(vld));
      checkOutput({tag, "_data"}, 64'(rsp_q[k].data), 64'(data));
      checkOutput({tag, "_err"}, 64'(rsp_q[k].err), 64'(err));
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 0);
    checkOutput({tag, "_start"}, 64'(sq_start), 0);
    checkOutput({tag, "_ready"}, 64'(req_ready), 0);
    checkOutput({tag, "_rspv"}, 64'(rsp_valid), 0);
    checkOutput({tag, "_rspd"}, 64'(rsp_data), 0);
    checkOutput({tag, "_rspe"}, 64'(rsp_err), 0);
    checkOutput({tag, "_num"}, 64'(sq_number), 0);
  endtask

  initial begin
    int exp_g2[4] = '{0, 1, 2, 3};
    int exp_d2[4] = '{10, 9, 7, 32};
    int exp_g6[4] = '{1, 3, 1, 3};
    int exp_d6[4] = '{20, 3, 20, 3};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    hold_mask = '0;
    tick();
    tick();
    checkIdleOutputs("reset");
    rst = 1'b0;
    clearLogs();

    // Single request on requester 0.
    applyStimulus(0, 144);
    runUntilRsp(1, 40, "t1_wait");
    checkOutput("t1_grants", 64'(grant_q.size()), 1);
    if (grant_q.size() > 0) checkOutput("t1_gidx", 64'(grant_q[0]), 0);
    checkRsp("t1", 0, 4'b0001, 12, 1'b0);
    repeat (4) tick();

    // All four at once from pointer 0.
    doReset();
    applyStimulus(0, 100);
    applyStimulus(1, 81);
    applyStimulus(2, 49);
    applyStimulus(3, 1024);
    runUntilRsp(4, 120, "t2_wait");
    for (int i = 0; i < 4; i++) begin
      if (grant_q.size() > i) checkOutput("t2_gidx", 64'(grant_q[i]), 64'(exp_g2[i]));
      checkRsp("t2", i, N_REQ'(1) << exp_g2[i], exp_d2[i], 1'b0);
    end
    repeat (4) tick();

    // Operands 1 then 0 back to back; sq_valid is high outside WAIT too.
    clearLogs();
    applyStimulus(2, 1);
    runUntilGrants(1, 20, "t3_grant");
    applyStimulus(2, 0);
    runUntilRsp(2, 40, "t3_wait");
    repeat (20) tick();
    checkOutput("t3_count", 64'(rsp_q.size()), 2);
    checkRsp("t3a", 0, 4'b0100, 1, 1'b0);
    checkRsp("t3b", 1, 4'b0100, 0, 1'b0);

    // Hung sqrt: TIMEOUT_CYC WAIT cycles follow ISSUE, RESPOND the cycle after.
    clearLogs();
    sqrt_dead = 1'b1;
    applyStimulus(0, 144);
    runUntilRsp(1, 60, "t4_wait");
    checkRsp("t4", 0, 4'b0001, 0, 1'b1);
    if (rsp_q.size() > 0 && rise_q.size() > 0)
      checkOutput("t4_latency", 64'(rsp_q[0].cyc - rise_q[0]), 64'(TIMEOUT_CYC + 1));
    sqrt_dead = 1'b0;
    repeat (4) tick();

    // Reset while waiting on the sqrt unit.
    clearLogs();
    sqrt_dead = 1'b1;
    applyStimulus(3, 144);
    for (int k = 0; k < 20 && rise_q.size() == 0; k++) tick();
    checkOutput("t5_issue", 64'(rise_q.size()), 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sqrt_dead = 1'b0;
    checkIdleOutputs("t5_rst");
    repeat (10) tick();
    checkOutput("t5_silent", 64'(rsp_q.size()), 0);
    applyStimulus(1, 49);
    runUntilRsp(1, 40, "t5_wait");
    checkRsp("t5", 0, 4'b0010, 7, 1'b0);
    repeat (4) tick();

    // Two requesters held continuously: strict alternation with a start-low gap.
    doReset();
    hold_mask = 4'b1010;
    applyStimulus(1, 400);
    applyStimulus(3, 9);
    runUntilGrants(4, 100, "t6_grants");
    hold_mask = '0;
    req_valid = '0;
    runUntilRsp(4, 60, "t6_wait");
    for (int i = 0; i < 4; i++) begin
      if (grant_q.size() > i) checkOutput("t6_gidx", 64'(grant_q[i]), 64'(exp_g6[i]));
      checkRsp("t6", i, N_REQ'(1) << exp_g6[i], exp_d6[i], 1'b0);
    end
    for (int i = 1; i < 4; i++)
      if (rise_q.size() > i) checkOutput("t6_interval", 64'(rise_q[i] - rise_q[i-1]), 64'(LAT + 4));
    checkOutput("t6_low_min", 64'(min_low >= 2), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
